// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle RV32I control FSM with memory watchdog and retire counter
module multicycle_control #(
   parameter int TIMEOUT_CYCLES = 15,
   parameter int ENABLE_UPPER   = 1,
   parameter int INSTRET_W      = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [6:0]           opcode,
   input  logic                 mem_ready,
   output logic                 PCWrite,
   output logic                 Branch,
   output logic                 PCSource,
   output logic                 IorD,
   output logic                 MemRead,
   output logic                 MemWrite,
   output logic                 IRWrite,
   output logic                 RegWrite,
   output logic [1:0]           MemToReg,
   output logic [1:0]           ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic [1:0]           ALUOp,
   output logic                 Jump,
   output logic                 instr_done,
   output logic [INSTRET_W-1:0] instret,
   output logic                 illegal,
   output logic                 fault,
   output logic [3:0]           state
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      EXEC_R   = 4'd2,
      EXEC_I   = 4'd3,
      MEM_ADDR = 4'd4,
      MEM_RD   = 4'd5,
      MEM_WB   = 4'd6,
      MEM_WR   = 4'd7,
      BRANCH   = 4'd8,
      JUMP     = 4'd9,
      UPPER    = 4'd10,
      ALU_WB   = 4'd11,
      TRAP     = 4'd12
   } state_t;

   localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

   state_t          cur, nxt;
   logic [WD_W-1:0] wd_cnt;
   logic            mem_wait;
   logic            wd_expire;

   assign state     = cur;
   assign mem_wait  = ((cur == FETCH) || (cur == MEM_RD) || (cur == MEM_WR)) && !mem_ready;
   assign wd_expire = (TIMEOUT_CYCLES != 0) && mem_wait && (wd_cnt == WD_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         cur     <= FETCH;
         wd_cnt  <= '0;
         instret <= '0;
         illegal <= 1'b0;
         fault   <= 1'b0;
      end else begin
         cur <= nxt;
         // counter restarts on every state change, so entering a memory state starts from zero
         if (nxt != cur)
            wd_cnt <= '0;
         else if (mem_wait)
            wd_cnt <= wd_cnt + WD_W'(1);
         if (instr_done)
            instret <= instret + INSTRET_W'(1);
         if (cur == DECODE && nxt == TRAP)
            illegal <= 1'b1;
         if (wd_expire)
            fault <= 1'b1;
      end
   end

   always_comb begin
      nxt        = cur;
      PCWrite    = 1'b0;
      Branch     = 1'b0;
      PCSource   = 1'b0;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemToReg   = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUOp      = 2'b00;
      Jump       = 1'b0;
      instr_done = 1'b0;
      case (cur)
         FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
            if (mem_ready)      nxt = DECODE;
            else if (wd_expire) nxt = TRAP;
         end
         DECODE: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b10;
            case (opcode)
               7'b0110011:             nxt = EXEC_R;
               7'b0010011:             nxt = EXEC_I;
               7'b0000011, 7'b0100011: nxt = MEM_ADDR;
               7'b1100011:             nxt = BRANCH;
               7'b1101111, 7'b1100111: nxt = JUMP;
               7'b0110111, 7'b0010111: nxt = (ENABLE_UPPER != 0) ? UPPER : TRAP;
               default:                nxt = TRAP;
            endcase
         end
         EXEC_R: begin
            ALUSrcA = 2'b01;
            ALUOp   = 2'b10;
            nxt     = ALU_WB;
         end
         EXEC_I: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            ALUOp   = 2'b10;
            nxt     = ALU_WB;
         end
         UPPER: begin
            ALUSrcA = opcode[5] ? 2'b11 : 2'b10;
            ALUSrcB = 2'b10;
            nxt     = ALU_WB;
         end
         MEM_ADDR: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            nxt     = opcode[5] ? MEM_WR : MEM_RD;
         end
         MEM_RD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (mem_ready)      nxt = MEM_WB;
            else if (wd_expire) nxt = TRAP;
         end
         MEM_WB: begin
            RegWrite   = 1'b1;
            MemToReg   = 2'b01;
            instr_done = 1'b1;
            nxt        = FETCH;
         end
         MEM_WR: begin
            MemWrite   = 1'b1;
            IorD       = 1'b1;
            instr_done = mem_ready;
            if (mem_ready)      nxt = FETCH;
            else if (wd_expire) nxt = TRAP;
         end
         ALU_WB: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
            nxt        = FETCH;
         end
         BRANCH: begin
            ALUSrcA    = 2'b01;
            ALUOp      = 2'b01;
            Branch     = 1'b1;
            PCSource   = 1'b1;
            instr_done = 1'b1;
            nxt        = FETCH;
         end
         JUMP: begin
            RegWrite   = 1'b1;
            MemToReg   = 2'b10;
            Jump       = 1'b1;
            PCWrite    = 1'b1;
            ALUSrcA    = opcode[3] ? 2'b10 : 2'b01;
            ALUSrcB    = 2'b10;
            instr_done = 1'b1;
            nxt        = FETCH;
         end
         TRAP:    nxt = TRAP;
         default: nxt = TRAP;
      endcase
      // reset masks everything, including the Mealy fetch strobes
      if (rst) begin
         PCWrite    = 1'b0;
         Branch     = 1'b0;
         PCSource   = 1'b0;
         IorD       = 1'b0;
         MemRead    = 1'b0;
         MemWrite   = 1'b0;
         IRWrite    = 1'b0;
         RegWrite   = 1'b0;
         MemToReg   = 2'b00;
         ALUSrcA    = 2'b00;
         ALUSrcB    = 2'b00;
         ALUOp      = 2'b00;
         Jump       = 1'b0;
         instr_done = 1'b0;
      end
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control FSM for the RV32I datapath. It replaces the single-cycle combinational decoder with a registered state machine that sequences each instruction through fetch, decode, execute, memory and writeback. Memory accesses use a `mem_ready` handshake with a stall-timeout watchdog. Illegal opcodes and memory timeouts trap, and the block counts retired instructions.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 15: consecutive not-ready cycles in a memory state before a fault. 0 disables the watchdog.
- `ENABLE_UPPER`, default 1: 1 decodes LUI/AUIPC; 0 treats them as illegal.
- `INSTRET_W`, default 32: width of the retired-instruction counter.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `opcode`  in  7  instr[6:0] from the instruction register; stable from DECODE until the instruction retires.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `PCWrite`  out  1  unconditional PC load.
- `Branch`  out  1  conditional PC load; datapath gates it with ALU zero.
- `PCSource`  out  1  0 = ALU result, 1 = ALUOut register.
- `IorD`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `MemRead`  out  1  memory read request.
- `MemWrite`  out  1  memory write request.
- `IRWrite`  out  1  load instruction register.
- `RegWrite`  out  1  register-file write.
- `MemToReg`  out  2  writeback source: 00 = ALUOut, 01 = MDR, 10 = PC+4.
- `ALUSrcA`  out  2  ALU A input: 00 = PC, 01 = rs1, 10 = OldPC, 11 = zero.
- `ALUSrcB`  out  2  ALU B input: 00 = rs2, 01 = constant 4, 10 = immediate.
- `ALUOp`  out  2  00 = add, 01 = branch compare, 10 = funct decode.
- `Jump`  out  1  jal/jalr in progress.
- `instr_done`  out  1  one-cycle pulse on the final cycle of each instruction.
- `instret`  out  `INSTRET_W`  retired-instruction count; wraps modulo 2^`INSTRET_W`.
- `illegal`  out  1  sticky; an undecodable opcode was seen.
- `fault`  out  1  sticky; the memory watchdog expired.
- `state`  out  4  current state encoding, for debug.

## Operation

States and encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WB=6, MEM_WR=7, BRANCH=8, JUMP=9, UPPER=10, ALU_WB=11, TRAP=12.

Any output not listed for a state is 0.

- **FETCH:** MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00. IRWrite and PCWrite are asserted only in the cycle `mem_ready`=1 (Mealy). On `mem_ready` go to DECODE.
- **DECODE:** ALUSrcA=10, ALUSrcB=10, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 or 1100111 → JUMP
  - 0110111 or 0010111 → UPPER, when `ENABLE_UPPER`=1
  - anything else → TRAP with `illegal`=1
- **EXEC_R:** A=01, B=00, ALUOp=10; go to ALU_WB.
- **EXEC_I:** A=01, B=10, ALUOp=10; go to ALU_WB.
- **UPPER:** B=10, ALUOp=00; A=11 when opcode[5]=1 (LUI), A=10 when opcode[5]=0 (AUIPC). Go to ALU_WB.
- **MEM_ADDR:** A=01, B=10, ALUOp=00; go to MEM_RD if opcode[5]=0, MEM_WR if opcode[5]=1.
- **MEM_RD:** MemRead=1, IorD=1; on `mem_ready` go to MEM_WB.
- **MEM_WB:** RegWrite=1, MemToReg=01; go to FETCH.
- **MEM_WR:** MemWrite=1, IorD=1; on `mem_ready` go to FETCH.
- **ALU_WB:** RegWrite=1, MemToReg=00; go to FETCH.
- **BRANCH:** A=01, B=00, ALUOp=01, Branch=1, PCSource=1; go to FETCH.
- **JUMP:** RegWrite=1, MemToReg=10, Jump=1, PCWrite=1, PCSource=0, B=10, ALUOp=00; A=10 when opcode[3]=1 (jal), A=01 when opcode[3]=0 (jalr). Go to FETCH.
- **TRAP:** all control outputs 0. Held until `rst`.

Retirement and watchdog:
- `instr_done`=1 in MEM_WB, ALU_WB, BRANCH, JUMP, and in MEM_WR when `mem_ready`=1. `instret` increments on the same edge.
- Watchdog counter clears whenever the FSM enters FETCH, MEM_RD or MEM_WR. It increments each cycle the FSM stays in one of these states with `mem_ready`=0.
- When the counter equals `TIMEOUT_CYCLES`-1 and `mem_ready`=0, next state is TRAP and `fault` sets. If `mem_ready`=1 in that same cycle, the access completes normally and no fault is raised.

## Timing

- While `rst`=1, every control output is forced to 0, including the Mealy terms.
- On the first edge with `rst`=1: state=FETCH, `instret`=0, watchdog counter=0, `illegal`=0, `fault`=0.
- Reset mid-instruction abandons it. No RegWrite, MemWrite or `instr_done` occurs in the first cycle after reset is released.
- Latency with zero wait states (`mem_ready` held 1):
  - R-type, I-type, LUI/AUIPC: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch, jal, jalr: 3 cycles
- Each memory wait cycle adds one cycle.
- `illegal`/`fault` rise in the first TRAP cycle and remain set until reset.
- `instret` wraps from all-ones to 0 with no flag.

## Test plan

- Reset, then feed add (0110011) with `mem_ready`=1 → state sequence 0,1,2,11,0; RegWrite=1 only in cycle 4; `instret`=1.
- Load (0000011) with `mem_ready` low for 3 cycles in MEM_RD → MEM_RD lasts 4 cycles, MemToReg=01 in MEM_WB, total 8 cycles, no fault.
- jal (1101111) → JUMP asserts PCWrite=1, RegWrite=1, MemToReg=10, ALUSrcA=10. For jalr (1100111), ALUSrcA=01.
- Opcode 1111111 → TRAP at cycle 3 with `illegal`=1. Outputs stay 0 for 20 cycles; `rst` returns state to 0 and clears `illegal`.
- `TIMEOUT_CYCLES`=15, store with `mem_ready` held 0 → TRAP after 15 MEM_WR cycles, `fault`=1, MemWrite=0 in TRAP. Repeat with `mem_ready`=1 on the 15th cycle → no fault, FETCH next.
- `ENABLE_UPPER`=0 with LUI → `illegal`. `ENABLE_UPPER`=1 with LUI → ALUSrcA=11 in UPPER. With `INSTRET_W`=4, retire 16 instructions → `instret` wraps to 0.
